// File: rtl/display_pkg.sv
// Shared display-path constants: glyph ROM geometry, glyph base addresses
// and player-state codes used by the renderers that share the glyph ROM.
package display_pkg;

    localparam int TCG_ADDR_W = 9;
    localparam int TCG_DATA_W = 8;

    localparam logic [TCG_ADDR_W-1:0] GLYPH_PLAY   = 9'h000;
    localparam logic [TCG_ADDR_W-1:0] GLYPH_PAUSE  = 9'h008;
    localparam logic [TCG_ADDR_W-1:0] GLYPH_CHANGE = 9'h010;

    typedef enum logic [1:0] {
        PLAYER_PAUSE  = 2'b00,
        PLAYER_PLAY   = 2'b01,
        PLAYER_CHANGE = 2'b10
    } player_state_e;

    // First row address of the glyph drawn for a given player state.
    function automatic logic [TCG_ADDR_W-1:0] glyph_base(player_state_e st);
        logic [TCG_ADDR_W-1:0] base;
        case (st)
            PLAYER_PLAY:   base = GLYPH_PLAY;
            PLAYER_CHANGE: base = GLYPH_CHANGE;
            default:       base = GLYPH_PAUSE;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector so the pointer sits at bit 0,
// take the first set bit, then rotate the one-hot result back.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] win_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   win_rot;

    // Rotate right by ptr: bit 0 of req_rot is requester ptr.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N_REQ-1:0];
    end

    // First set bit in rotated order.
    always_comb begin
        win_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rot[i] && !found) begin
                win_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Rotate the one-hot winner left by ptr back into requester order.
    always_comb begin
        win_dbl = {win_rot, win_rot} << ptr;
        winner  = win_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/tcgrom_arbiter.sv
// Glyph ROM arbiter: grants one renderer per clock in round-robin order,
// supports a lock for multi-row glyph bursts, and steers each ROM read
// back to the renderer that issued it.
module tcgrom_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = TCG_ADDR_W,
    parameter int DATA_W  = TCG_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  ptr;
    logic              lock_on;
    logic [PTR_W-1:0]  lock_idx;

    logic [N_REQ-1:0]  pick_winner;
    logic              pick_found;
    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  gnt_int;
    logic [PTR_W-1:0]  gnt_idx;
    logic              xfer;
    logic [PTR_W-1:0]  ptr_next;

    logic [ADDR_W-1:0] addr_sel;
    logic [ADDR_W-1:0] last_addr;

    logic [N_REQ-1:0]  rsp_pipe [ROM_LAT];

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // Grant: a live lock owner wins outright; otherwise round-robin from ptr.
    // A lock owner that dropped req falls through to normal arbitration.
    always_comb begin
        owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << lock_idx;
        gnt_int  = '0;
        if (!reset) begin
            if (lock_on && req[lock_idx]) begin
                gnt_int = owner_oh;
            end else if (pick_found) begin
                gnt_int = pick_winner;
            end
        end
    end

    // Encode the granted requester and select its address.
    always_comb begin
        gnt_idx  = '0;
        addr_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_int[i]) begin
                gnt_idx  = PTR_W'(i);
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Transfer detection and the pointer value following the granted slot.
    always_comb begin
        xfer     = |(req & gnt_int);
        ptr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end

    // Pointer and lock owner update; any cycle without a transfer drops the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            lock_on  <= 1'b0;
            lock_idx <= '0;
        end else if (xfer) begin
            if (req_lock[gnt_idx]) begin
                lock_on  <= 1'b1;
                lock_idx <= gnt_idx;
            end else begin
                lock_on  <= 1'b0;
                ptr      <= ptr_next;
            end
        end else begin
            lock_on <= 1'b0;
        end
    end

    // Remember the last granted address so rom_addr is stable while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= '0;
        end else if (xfer) begin
            last_addr <= addr_sel;
        end
    end

    // Response pipeline: each stage carries the grant vector one clock further.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                rsp_pipe[i] <= '0;
            end
        end else begin
            rsp_pipe[0] <= gnt_int;
            for (int i = 1; i < ROM_LAT; i++) begin
                rsp_pipe[i] <= rsp_pipe[i-1];
            end
        end
    end

    // Output drive; reset forces the ROM port and response strobe quiet at once.
    always_comb begin
        gnt       = gnt_int;
        rom_en    = |gnt_int;
        rom_addr  = reset ? '0 : (rom_en ? addr_sel : last_addr);
        rsp_valid = reset ? '0 : rsp_pipe[ROM_LAT-1];
        rsp_data  = rom_data;
    end

endmodule

// File: tb/tb_tcgrom_arbiter.sv
// Directed bench for tcgrom_arbiter: one instance at ROM_LAT=1 and one at
// ROM_LAT=3, both driven by the same stimulus, each with its own ROM model.
module tb_tcgrom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_lock;
    logic [26:0] req_addr;

    logic [2:0]  gnt_a, rsp_valid_a;
    logic        rom_en_a;
    logic [8:0]  rom_addr_a;
    logic [7:0]  rom_data_a, rsp_data_a;

    logic [2:0]  gnt_b, rsp_valid_b;
    logic        rom_en_b;
    logic [8:0]  rom_addr_b;
    logic [7:0]  rom_data_b, rsp_data_b;
    logic [7:0]  rom_b_s1, rom_b_s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcgrom_arbiter #(.N_REQ(3), .ADDR_W(9), .DATA_W(8), .ROM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a)
    );

    tcgrom_arbiter #(.N_REQ(3), .ADDR_W(9), .DATA_W(8), .ROM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b)
    );

    function automatic logic [7:0] glyph(logic [8:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [8:0] addr_of(int j);
        return 9'(j * 8);
    endfunction

    always @(posedge clk) rom_data_a <= glyph(rom_addr_a);

    always @(posedge clk) begin
        rom_b_s1   <= glyph(rom_addr_b);
        rom_b_s2   <= rom_b_s1;
        rom_data_b <= rom_b_s2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 3'b000;
        req_lock = 3'b000;
        req_addr = {9'h010, 9'h008, 9'h000};
        tick();
        tick();
        req = 3'b111;
        settle();
        check("reset_gnt",       32'(gnt_a),       32'h0);
        check("reset_rom_en",    32'(rom_en_a),    32'h0);
        check("reset_rsp_valid", 32'(rsp_valid_a), 32'h0);
        check("reset_rom_addr",  32'(rom_addr_a),  32'h0);
        check("reset_rsp_b",     32'(rsp_valid_b), 32'h0);

        // single requester
        tick();
        reset = 1'b0;
        req   = 3'b010;
        settle();
        check("single_gnt",      32'(gnt_a),      32'h2);
        check("single_rom_en",   32'(rom_en_a),   32'h1);
        check("single_rom_addr", 32'(rom_addr_a), 32'h008);
        tick();
        req = 3'b000;
        settle();
        check("single_rsp_valid", 32'(rsp_valid_a), 32'h2);
        check("single_rsp_data",  32'(rsp_data_a),  32'hAD);
        check("idle_gnt",         32'(gnt_a),       32'h0);
        check("idle_rom_en",      32'(rom_en_a),    32'h0);
        check("idle_addr_hold",   32'(rom_addr_a),  32'h008);

        // all requesting, fair rotation, no bubbles
        reset_pulse();
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("rr_gnt",    32'(gnt_a),    32'(3'b001 << (k % 3)));
            check("rr_rom_en", 32'(rom_en_a), 32'h1);
            if (k > 0) begin
                check("rr_rsp_valid", 32'(rsp_valid_a), 32'(3'b001 << ((k - 1) % 3)));
                check("rr_rsp_data",  32'(rsp_data_a),  32'(glyph(addr_of((k - 1) % 3))));
            end
            tick();
        end
        req = 3'b000;
        settle();
        check("rr_tail_rsp", 32'(rsp_valid_a), 32'h4);
        check("rr_tail_gnt", 32'(gnt_a),       32'h0);

        // lock burst on requester 2 while requester 0 also waits
        reset_pulse();
        req = 3'b010;
        settle();
        check("lock_setup_gnt", 32'(gnt_a), 32'h2);
        tick();
        req      = 3'b101;
        req_lock = 3'b100;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) req_lock = 3'b000;
            settle();
            check("lock_burst_gnt", 32'(gnt_a), 32'h4);
            tick();
        end
        settle();
        check("lock_after_gnt", 32'(gnt_a), 32'h1);

        // lock owner drops req; stray lock on an idle requester is ignored
        tick();
        req      = 3'b100;
        req_lock = 3'b100;
        settle();
        check("drop_lock_gnt", 32'(gnt_a), 32'h4);
        tick();
        req      = 3'b001;
        req_lock = 3'b100;
        settle();
        check("drop_same_cycle_gnt", 32'(gnt_a), 32'h1);
        tick();
        req      = 3'b110;
        req_lock = 3'b000;
        settle();
        check("drop_lock_cleared", 32'(gnt_a), 32'h2);

        // reset in the middle of a stream
        tick();
        req = 3'b111;
        tick();
        tick();
        reset = 1'b1;
        settle();
        check("midrst_gnt",    32'(gnt_a),       32'h0);
        check("midrst_rom_en", 32'(rom_en_a),    32'h0);
        check("midrst_rsp",    32'(rsp_valid_a), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        check("postrst_rsp", 32'(rsp_valid_a), 32'h0);
        check("postrst_gnt", 32'(gnt_a),       32'h1);
        tick();
        settle();
        check("postrst_rsp2", 32'(rsp_valid_a), 32'h1);

        // three-cycle ROM latency, continuous requests
        reset_pulse();
        req = 3'b111;
        for (int k = 0; k < 23; k++) begin
            settle();
            check("lat3_gnt", 32'(gnt_b), 32'(3'b001 << (k % 3)));
            if (k >= 3) begin
                check("lat3_rsp_valid", 32'(rsp_valid_b), 32'(3'b001 << ((k - 3) % 3)));
                check("lat3_rsp_data",  32'(rsp_data_b),  32'(glyph(addr_of((k - 3) % 3))));
            end else begin
                check("lat3_rsp_idle", 32'(rsp_valid_b), 32'h0);
            end
            tick();
        end
        req = 3'b000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcgrom_arbiter.md
Name: tcgrom_arbiter

Overview:
- Shares the single character-glyph ROM (tcgrom) among several glyph renderers: the state-symbol renderer, the song-title text and the clock digits.
- Round-robin arbitrates one ROM read per clock and forwards the granted address to the ROM.
- Tracks each in-flight read and returns the ROM data to the requester that issued it, with a one-hot response strobe.
- Sits between the char_pixel-style renderers and the tcgrom instance in the display path.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 9, tcgrom address width.
- DATA_W, 8, tcgrom data width (one glyph row).
- ROM_LAT, 1, ROM read latency in clocks, address-valid to data-valid (1..4).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester read request; held high until granted.
- req_addr  input  N_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_lock  input  N_REQ  requester wants to keep the grant next cycle (multi-row glyph burst).
- gnt  output  N_REQ  one-hot grant, same cycle as the request.
- rom_en  output  1  ROM read enable.
- rom_addr  output  ADDR_W  ROM address.
- rom_data  input  DATA_W  ROM read data, valid ROM_LAT clocks after rom_en.
- rsp_valid  output  N_REQ  one-hot response strobe.
- rsp_data  output  DATA_W  response data (rom_data passthrough).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - Priority pointer = 0 and lock owner = none.
  - Response pipeline cleared.
  - gnt = 0, rom_en = 0, rsp_valid = 0, rom_addr = 0.
- Grant (combinational from registered state):
  - If a lock owner is set and its req is high, the owner is granted.
  - Otherwise the first requester with req high is granted, searching from pointer upward with wrap-around.
  - At most one gnt bit is high.
  - gnt is 0 in any cycle where reset is high.
- ROM drive:
  - rom_en = |gnt.
  - rom_addr = address of the granted requester; holds its previous value when there is no grant.
- Handshake:
  - A transfer occurs when req[i] and gnt[i] are both high.
  - A requester that sees req[i] && gnt[i] may change its address or drop req the next cycle.
- Pointer update on each transfer to requester i:
  - If req_lock[i] = 1: the lock owner becomes i and the pointer is unchanged.
  - If req_lock[i] = 0: the lock owner is cleared and the pointer becomes (i+1) mod N_REQ.
  - No transfer: the pointer is unchanged and the lock is cleared.
- Lock release:
  - The lock is released when the owner drops req or deasserts req_lock on a granted cycle.
  - A lock owner with req low is never granted. Arbitration proceeds normally in that same cycle.
- Response pipeline:
  - A shift register ROM_LAT deep of gnt vectors.
  - rsp_valid at cycle T+ROM_LAT equals gnt at cycle T.
  - rsp_data = rom_data combinationally.
  - rsp_valid = 0 whenever no read matured that cycle.
- Throughput: one read per clock sustained; no bubbles between back-to-back grants.
- Fairness: with all requesters continuously requesting and no lock, each is granted exactly once every N_REQ cycles.
- Reset mid-operation:
  - In-flight reads are discarded.
  - rsp_valid stays 0 until ROM_LAT cycles after the first post-reset grant.
- Illegal inputs: req_lock on a requester whose req is low is ignored.

Decomposition:
- Shared package (display_pkg):
  - TCG_ADDR_W = 9, TCG_DATA_W = 8.
  - Glyph base addresses: PLAY 9'h000, PAUSE 9'h008, CHANGE 9'h010.
  - Player-state codes: PAUSE 2'b00, PLAY 2'b01, CHANGE 2'b10.
- Sub-module rr_pick:
  - Combinational rotate-and-find-first-one over N_REQ bits, given the pointer.
  - Returns a one-hot winner and a found flag.
  - Reused by any future display-resource arbiter.

Test Plan:
- Single requester: reset, then req[1]=1 with addr 9'h008 for one cycle -> gnt=3'b010, rom_en=1, rom_addr=9'h008 that cycle; rsp_valid=3'b010 with rsp_data = ROM row one cycle later (ROM_LAT=1).
- All three req held high for 6 cycles, no lock -> gnt sequence 001,010,100,001,010,100; rsp_valid is the same sequence delayed 1 cycle; no idle cycles.
- Lock burst: req[2] with req_lock=1 for 4 cycles while req[0] is also high -> gnt=100 four times, then 001 after req_lock drops on the last beat.
- Lock owner drops req while req[0] is high -> gnt=001 that same cycle; lock cleared.
- Reset mid-burst: grants issued in cycles 10-11, reset high in cycle 12 -> rsp_valid=0 in cycles 12-13; pointer=0; the first grant after reset goes to requester 0 when all request.
- ROM_LAT=3, all requesting -> rsp_valid identity matches the gnt issued 3 cycles earlier for 20 consecutive cycles.
